// File: rtl/snake_body_updater_if.sv
// Bus between the snake body updater and its controller / segment register file.
// The controller side (master) supplies tick, steering and the segment array; the updater (slave) returns the write port and status.
interface snake_body_updater_if #(
   parameter int SLOTS = 10
);
   logic                  tick;
   logic [1:0]            direction;
   logic [31:0]           length;
   logic [SLOTS*32-1:0]   segments_in;
   logic [31:0]           value_out;
   logic [31:0]           index;
   logic                  write_enable;
   logic                  busy;
   logic                  done;
   logic [1:0]            heading;

   modport master (
      output tick, direction, length, segments_in,
      input  value_out, index, write_enable, busy, done, heading
   );

   modport slave (
      input  tick, direction, length, segments_in,
      output value_out, index, write_enable, busy, done, heading
   );
endinterface

// File: rtl/snake_body_updater.sv
// Advances the snake one cell per tick: shifts body slots tail-first into the
// segment register file, then writes the moved head with grid wrap-around.
module snake_body_updater #(
   parameter int SLOTS  = 10,
   parameter int GRID_W = 40,
   parameter int GRID_H = 30
) (
   input logic                  clock,
   input logic                  reset,
   snake_body_updater_if.slave  bus
);
   localparam int IDX_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_HEAD  = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   state_t              state_r, state_s;
   logic [31:0]         k_r, k_s;
   logic [1:0]          heading_r, heading_s;
   logic [31:0]         seg0_r, seg0_s;
   logic [31:0]         len_eff_s;
   logic                accept_s;
   logic [31:0]         slots_s [SLOTS];
   logic [IDX_W-1:0]    src_sel_s;
   logic [31:0]         value_s, index_s;
   logic                we_s, busy_s, done_s;
   logic [31:0]         value_r, index_r;
   logic                we_r, busy_r, done_r;

   function automatic logic [31:0] move_head(input logic [31:0] seg, input logic [1:0] dir);
      logic [15:0] x;
      logic [15:0] y;
      x = seg[31:16];
      y = seg[15:0];
      case (dir)
         2'd0:    y = (y == 16'd0) ? 16'(GRID_H - 1) : y - 16'd1;
         2'd1:    x = (x == 16'(GRID_W - 1)) ? 16'd0 : x + 16'd1;
         2'd2:    y = (y == 16'(GRID_H - 1)) ? 16'd0 : y + 16'd1;
         2'd3:    x = (x == 16'd0) ? 16'(GRID_W - 1) : x - 16'd1;
         default: x = seg[31:16];
      endcase
      return {x, y};
   endfunction

   // Unpack the flat segment bus into per-slot words.
   always_comb begin
      for (int i = 0; i < SLOTS; i++) begin
         slots_s[i] = bus.segments_in[32*i +: 32];
      end
   end

   // Clamp requested length into 1..SLOTS.
   always_comb begin
      if (bus.length == 32'd0) begin
         len_eff_s = 32'd1;
      end else if (bus.length > 32'(SLOTS)) begin
         len_eff_s = 32'(SLOTS);
      end else begin
         len_eff_s = bus.length;
      end
   end

   assign accept_s = (state_r == ST_IDLE) && bus.tick;

   // Heading and head source are captured only when a tick is accepted; reversals keep the old heading.
   always_comb begin
      heading_s = heading_r;
      seg0_s    = seg0_r;
      if (accept_s) begin
         if (bus.direction != (heading_r ^ 2'b10)) begin
            heading_s = bus.direction;
         end else begin
            heading_s = heading_r;
         end
         seg0_s = slots_s[0];
      end else begin
         heading_s = heading_r;
         seg0_s    = seg0_r;
      end
   end

   // Next-state and slot counter; k is the slot index presented while in SHIFT.
   always_comb begin
      state_s = state_r;
      k_s     = k_r;
      case (state_r)
         ST_IDLE: begin
            if (bus.tick) begin
               if (len_eff_s > 32'd1) begin
                  state_s = ST_SHIFT;
                  k_s     = len_eff_s - 32'd1;
               end else begin
                  state_s = ST_HEAD;
                  k_s     = 32'd0;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            if (k_r <= 32'd1) begin
               state_s = ST_HEAD;
               k_s     = 32'd0;
            end else begin
               k_s = k_r - 32'd1;
            end
         end
         ST_HEAD: state_s = ST_DONE;
         ST_DONE: state_s = ST_IDLE;
         default: begin
            state_s = ST_IDLE;
            k_s     = 32'd0;
         end
      endcase
   end

   // Source slot for a shift write is the one just below the destination.
   always_comb begin
      if ((k_s >= 32'd1) && (k_s < 32'(SLOTS))) begin
         src_sel_s = IDX_W'(k_s - 32'd1);
      end else begin
         src_sel_s = {IDX_W{1'b0}};
      end
   end

   // Output values are decoded from the upcoming state so the write port is registered.
   always_comb begin
      value_s = 32'd0;
      index_s = 32'd0;
      we_s    = 1'b0;
      busy_s  = 1'b0;
      done_s  = 1'b0;
      case (state_s)
         ST_SHIFT: begin
            value_s = slots_s[src_sel_s];
            index_s = k_s;
            we_s    = 1'b1;
            busy_s  = 1'b1;
         end
         ST_HEAD: begin
            value_s = move_head(seg0_s, heading_s);
            index_s = 32'd0;
            we_s    = 1'b1;
            busy_s  = 1'b1;
         end
         ST_DONE: begin
            done_s = 1'b1;
            busy_s = 1'b1;
         end
         ST_IDLE: begin
            busy_s = 1'b0;
         end
         default: begin
            busy_s = 1'b0;
         end
      endcase
   end

   // State, counter and latched move context.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_r   <= ST_IDLE;
         k_r       <= 32'd0;
         heading_r <= 2'd1;
         seg0_r    <= 32'd0;
      end else begin
         state_r   <= state_s;
         k_r       <= k_s;
         heading_r <= heading_s;
         seg0_r    <= seg0_s;
      end
   end

   // Registered write port and status outputs.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         value_r <= 32'd0;
         index_r <= 32'd0;
         we_r    <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         value_r <= value_s;
         index_r <= index_s;
         we_r    <= we_s;
         busy_r  <= busy_s;
         done_r  <= done_s;
      end
   end

   assign bus.value_out    = value_r;
   assign bus.index        = index_r;
   assign bus.write_enable = we_r;
   assign bus.busy         = busy_r;
   assign bus.done         = done_r;
   assign bus.heading      = heading_r;

endmodule

// File: tb/tb_snake_body_updater.sv
// Directed bench for snake_body_updater with a behavioural segment register file in the loop.
module tb_snake_body_updater;
   logic clock;
   logic reset;
   snake_body_updater_if #(.SLOTS(10)) bus ();

   snake_body_updater #(.SLOTS(10), .GRID_W(40), .GRID_H(30)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   logic [31:0] rf [10];
   logic [31:0] load_val [10];
   logic        load_en;
   int          n_cmp;
   int          n_bad;
   logic [31:0] w_idx [32];
   logic [31:0] w_val [32];
   int          w_cnt;
   int          done_at;
   int          done_cnt;

   always @(posedge clock) begin
      if (load_en) begin
         for (int i = 0; i < 10; i++) rf[i] <= load_val[i];
      end else if (bus.write_enable && (bus.index < 32'd10)) begin
         rf[bus.index] <= bus.value_out;
      end
   end

   always_comb begin
      for (int i = 0; i < 10; i++) bus.segments_in[32*i +: 32] = rf[i];
   end

   function automatic logic [31:0] seg(input int x, input int y);
      return {16'(x), 16'(y)};
   endfunction

   task automatic load_rf();
      @(negedge clock);
      load_en = 1'b1;
      @(negedge clock);
      load_en = 1'b0;
   endtask

   task automatic run_move(input logic [1:0] dir, input logic [31:0] len, input bit hold);
      w_cnt = 0; done_cnt = 0; done_at = -1;
      bus.direction = dir; bus.length = len; bus.tick = 1'b1;
      for (int c = 1; c <= 40; c++) begin
         @(negedge clock);
         if (!hold) bus.tick = 1'b0;
         if (bus.write_enable) begin
            if (w_cnt < 32) begin
               w_idx[w_cnt] = bus.index;
               w_val[w_cnt] = bus.value_out;
            end
            w_cnt++;
         end
         if (bus.done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
            bus.tick = 1'b0;
         end
         if ((done_at >= 0) && (c >= done_at + 3)) break;
      end
      n_cmp++;
      if (done_at < 0) begin
         n_bad++;
         $display("FAIL move_timeout: done=never required=within 40 cycles");
      end
   endtask

   task automatic test_reset();
      reset = 1'b0; bus.tick = 1'b0; bus.direction = 2'd0; bus.length = 32'd0; load_en = 1'b0;
      for (int i = 0; i < 10; i++) load_val[i] = 32'd0;
      @(negedge clock); @(negedge clock);
      n_cmp += 6;
      if (bus.write_enable !== 1'b0) begin n_bad++; $display("FAIL reset_we: got=%b exp=0", bus.write_enable); end
      if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got=%b exp=0", bus.busy); end
      if (bus.done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got=%b exp=0", bus.done); end
      if (bus.heading !== 2'd1) begin n_bad++; $display("FAIL reset_heading: got=%0d exp=1", bus.heading); end
      if (bus.index !== 32'd0) begin n_bad++; $display("FAIL reset_index: got=%0d exp=0", bus.index); end
      if (bus.value_out !== 32'd0) begin n_bad++; $display("FAIL reset_value: got=%h exp=0", bus.value_out); end
      reset = 1'b1;
      @(negedge clock);
   endtask

   task automatic test_shift3();
      logic [31:0] ei [3];
      logic [31:0] ev [3];
      ei = '{32'd2, 32'd1, 32'd0};
      ev = '{seg(4,5), seg(5,5), seg(6,5)};
      load_val[0] = seg(5,5); load_val[1] = seg(4,5); load_val[2] = seg(3,5);
      load_rf();
      run_move(2'd1, 32'd3, 1'b0);
      n_cmp += 2;
      if (w_cnt !== 3) begin n_bad++; $display("FAIL shift3_count: got=%0d exp=3", w_cnt); end
      if (done_at !== 4) begin n_bad++; $display("FAIL shift3_done_lat: got=%0d exp=4", done_at); end
      for (int i = 0; i < 3; i++) begin
         n_cmp += 2;
         if (w_idx[i] !== ei[i]) begin n_bad++; $display("FAIL shift3_idx%0d: got=%0d exp=%0d", i, w_idx[i], ei[i]); end
         if (w_val[i] !== ev[i]) begin n_bad++; $display("FAIL shift3_val%0d: got=%h exp=%h", i, w_val[i], ev[i]); end
      end
   endtask

   task automatic test_wrap_right();
      load_val[0] = seg(39,10);
      load_rf();
      run_move(2'd1, 32'd1, 1'b0);
      n_cmp += 4;
      if (w_cnt !== 1) begin n_bad++; $display("FAIL wrapr_count: got=%0d exp=1", w_cnt); end
      if (done_at !== 2) begin n_bad++; $display("FAIL wrapr_done_lat: got=%0d exp=2", done_at); end
      if (w_idx[0] !== 32'd0) begin n_bad++; $display("FAIL wrapr_idx: got=%0d exp=0", w_idx[0]); end
      if (w_val[0] !== seg(0,10)) begin n_bad++; $display("FAIL wrapr_val: got=%h exp=%h", w_val[0], seg(0,10)); end
   endtask

   task automatic test_up_and_reversal();
      load_val[0] = seg(7,0);
      load_rf();
      run_move(2'd0, 32'd1, 1'b0);
      n_cmp += 2;
      if (w_val[0] !== seg(7,29)) begin n_bad++; $display("FAIL up_wrap_val: got=%h exp=%h", w_val[0], seg(7,29)); end
      if (bus.heading !== 2'd0) begin n_bad++; $display("FAIL up_heading: got=%0d exp=0", bus.heading); end
      run_move(2'd2, 32'd1, 1'b0);
      n_cmp += 2;
      if (bus.heading !== 2'd0) begin n_bad++; $display("FAIL reversal_heading: got=%0d exp=0", bus.heading); end
      if (w_val[0] !== seg(7,28)) begin n_bad++; $display("FAIL reversal_val: got=%h exp=%h", w_val[0], seg(7,28)); end
   endtask

   task automatic test_len_zero();
      load_val[0] = seg(3,3);
      load_rf();
      run_move(2'd0, 32'd0, 1'b0);
      n_cmp += 3;
      if (w_cnt !== 1) begin n_bad++; $display("FAIL len0_count: got=%0d exp=1", w_cnt); end
      if (w_idx[0] !== 32'd0) begin n_bad++; $display("FAIL len0_idx: got=%0d exp=0", w_idx[0]); end
      if (w_val[0] !== seg(3,2)) begin n_bad++; $display("FAIL len0_val: got=%h exp=%h", w_val[0], seg(3,2)); end
   endtask

   task automatic test_len_clamp();
      for (int i = 0; i < 10; i++) load_val[i] = seg(i, 20);
      load_rf();
      run_move(2'd1, 32'd15, 1'b0);
      n_cmp += 2;
      if (w_cnt !== 10) begin n_bad++; $display("FAIL clamp_count: got=%0d exp=10", w_cnt); end
      if (done_at !== 11) begin n_bad++; $display("FAIL clamp_done_lat: got=%0d exp=11", done_at); end
      for (int i = 0; i < 10; i++) begin
         n_cmp += 2;
         if (w_idx[i] !== 32'(9 - i)) begin n_bad++; $display("FAIL clamp_idx%0d: got=%0d exp=%0d", i, w_idx[i], 9 - i); end
         if (w_val[i] !== ((i == 9) ? seg(1,20) : seg(8 - i, 20))) begin
            n_bad++; $display("FAIL clamp_val%0d: got=%h", i, w_val[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] ev [5];
      ev = '{seg(13,7), seg(12,7), seg(11,7), seg(10,7), seg(11,7)};
      for (int i = 0; i < 10; i++) load_val[i] = seg(10 + i, 7);
      load_rf();
      run_move(2'd1, 32'd5, 1'b1);
      n_cmp += 3;
      if (w_cnt !== 5) begin n_bad++; $display("FAIL b2b_count: got=%0d exp=5", w_cnt); end
      if (done_cnt !== 1) begin n_bad++; $display("FAIL b2b_done_count: got=%0d exp=1", done_cnt); end
      if (done_at !== 6) begin n_bad++; $display("FAIL b2b_done_lat: got=%0d exp=6", done_at); end
      for (int i = 0; i < 5; i++) begin
         n_cmp += 2;
         if (w_idx[i] !== 32'(4 - i)) begin n_bad++; $display("FAIL b2b_idx%0d: got=%0d exp=%0d", i, w_idx[i], 4 - i); end
         if (w_val[i] !== ev[i]) begin n_bad++; $display("FAIL b2b_val%0d: got=%h exp=%h", i, w_val[i], ev[i]); end
      end
   endtask

   task automatic test_reset_abort();
      for (int i = 0; i < 10; i++) load_val[i] = seg(20 + i, 4);
      load_rf();
      bus.direction = 2'd2; bus.length = 32'd5; bus.tick = 1'b1;
      @(negedge clock);
      bus.tick = 1'b0;
      n_cmp += 1;
      if (bus.heading !== 2'd2) begin n_bad++; $display("FAIL abort_heading_set: got=%0d exp=2", bus.heading); end
      @(negedge clock);
      n_cmp += 2;
      if (bus.write_enable !== 1'b1) begin n_bad++; $display("FAIL abort_second_we: got=%b exp=1", bus.write_enable); end
      if (bus.index !== 32'd3) begin n_bad++; $display("FAIL abort_second_idx: got=%0d exp=3", bus.index); end
      reset = 1'b0;
      #1;
      n_cmp += 3;
      if (bus.write_enable !== 1'b0) begin n_bad++; $display("FAIL abort_we: got=%b exp=0", bus.write_enable); end
      if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got=%b exp=0", bus.busy); end
      if (bus.done !== 1'b0) begin n_bad++; $display("FAIL abort_done: got=%b exp=0", bus.done); end
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      n_cmp += 2;
      if (bus.heading !== 2'd1) begin n_bad++; $display("FAIL abort_heading_rst: got=%0d exp=1", bus.heading); end
      if (bus.busy !== 1'b0) begin n_bad++; $display("FAIL abort_idle: got=%b exp=0", bus.busy); end
      for (int i = 0; i < 10; i++) load_val[i] = seg(30 + i, 9);
      load_rf();
      run_move(2'd1, 32'd5, 1'b0);
      n_cmp += 3;
      if (w_cnt !== 5) begin n_bad++; $display("FAIL fresh_count: got=%0d exp=5", w_cnt); end
      if (done_at !== 6) begin n_bad++; $display("FAIL fresh_done_lat: got=%0d exp=6", done_at); end
      if (w_val[4] !== seg(31,9)) begin n_bad++; $display("FAIL fresh_head: got=%h exp=%h", w_val[4], seg(31,9)); end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      test_reset();
      test_shift3();
      test_wrap_right();
      test_up_and_reversal();
      test_len_zero();
      test_len_clamp();
      test_back_to_back();
      test_reset_abort();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/snake_body_updater.md
Name: snake_body_updater

Overview:
- Sequencer that advances the snake by one cell per game tick.
- Sits directly upstream of the 10-slot snake segment register file: reads the packed segment array, drives its write port (value, index, enable).
- Shifts body segments tail-first, then writes the new head computed from the steering direction, with grid wrap-around.
- Rejects 180-degree reversals.

Parameters:
- SLOTS, 10, number of segment slots in the register file; max snake length.
- GRID_W, 40, grid width in cells; x range 0..GRID_W-1.
- GRID_H, 30, grid height in cells; y range 0..GRID_H-1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- tick  input  1  one-cycle start pulse; begin one move.
- direction  input  2  requested heading: 0 up, 1 right, 2 down, 3 left.
- length  input  32  active snake length in segments.
- segments_in  input  SLOTS*32  packed segment array from the register file; slot i at [32*(i+1)-1:32*i].
- value_out  output  32  segment value to write.
- index  output  32  slot number to write.
- write_enable  output  1  write strobe to the register file.
- busy  output  1  high from the cycle after an accepted tick until done.
- done  output  1  one-cycle pulse after the head write.
- heading  output  2  currently applied direction.

Behaviour:
- Segment encoding: bits [31:16] = x, bits [15:0] = y, both unsigned.
- Reset (reset = 0, asynchronous):
  - State goes to IDLE.
  - value_out, index, write_enable, busy and done all go to 0.
  - heading goes to 1 (right).
- All outputs are registered.
- Effective length L:
  - length = 0 gives L = 1.
  - length > SLOTS gives L = SLOTS.
  - Otherwise L = length.
  - L is latched on tick acceptance.
- Direction latch on tick acceptance:
  - If direction == heading XOR 2 (a reversal), heading is kept.
  - Otherwise heading <= direction.
- The head source, seg0 = slot 0 of segments_in, is latched on tick acceptance.
- States:
  - IDLE: a tick moves to SHIFT if L > 1, else to HEAD. All other inputs are ignored.
  - SHIFT: a counter k starts at L-1. Each cycle drives index = k, value_out = slot k-1 of segments_in, write_enable = 1, then decrements k. After the k = 1 write, go to HEAD.
  - The tail-first order guarantees slot k-1 is unmodified when read. segments_in reflects the previous cycle's writes, and this is correct by construction.
  - HEAD: one cycle with index = 0, write_enable = 1, value_out = moved seg0, then go to DONE.
  - DONE: done = 1 for exactly one cycle, write_enable = 0, then back to IDLE.
- Move rules, with wrap-around at the grid edges:
  - up: y = (y == 0) ? GRID_H-1 : y-1
  - down: y = (y == GRID_H-1) ? 0 : y+1
  - right: x = (x == GRID_W-1) ? 0 : x+1
  - left: x = (x == 0) ? GRID_W-1 : x-1
- Latency: from the tick cycle, the first write appears on the next edge. There are L write cycles, then done, so done asserts L+1 cycles after the tick.
- busy is 1 in SHIFT, HEAD and DONE.
- A tick while busy is ignored, not queued.
- Reset mid-operation aborts immediately. Partially shifted slots are left as written, with no rollback.
- write_enable never asserts outside SHIFT and HEAD.
- index is always < L.

Test Plan:
- Reset, then L = 3, segments {(5,5),(4,5),(3,5)}, direction 1, tick.
  - Writes: idx2 = (4,5), idx1 = (5,5), idx0 = (6,5).
  - done appears 4 cycles after the tick.
- Head (39,10), heading right, direction 1, L = 1, tick.
  - Single write idx0 = (0,10); no SHIFT cycles.
  - done 2 cycles after the tick.
- Head (7,0), direction 0 (up) accepted, tick: idx0 = (7,29).
  - Then direction 2 (down, a reversal), tick: heading stays 0 and the head goes to (7,28).
- length = 0 gives exactly one write (idx0).
- length = 15 gives 10 writes, idx 9 down to 0.
- Tick asserted again during SHIFT with L = 5: still exactly 5 writes and one done, with no second sequence.
- Assert reset after the second write of an L = 5 move: write_enable, busy and done are 0 the same cycle. After release, IDLE, heading = 1, and a fresh tick runs a full sequence.
